// File: rtl/io_bank_ctrl.sv
// IO bank controller: per-pad shadow/active configuration with a guarded commit,
// plus a synchronised, optionally debounced input path with sticky rise events.
module io_bank_ctrl #(
    parameter int NUM_PADS     = 8,
    parameter int IOCELL_CFG_W = 3,
    parameter int GUARD_CYCLES = 2,
    parameter int FILTER_LEN   = 4,
    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
    localparam int WW = IOCELL_CFG_W + 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             cfg_valid_i,
    output logic                             cfg_ready_o,
    input  logic [AW-1:0]                    cfg_addr_i,
    input  logic [WW-1:0]                    cfg_wdata_i,
    input  logic                             cfg_apply_i,
    output logic                             cfg_busy_o,
    input  logic [NUM_PADS-1:0]              core_out_i,
    output logic [NUM_PADS-1:0]              core_in_o,
    output logic [NUM_PADS-1:0]              evt_rise_o,
    input  logic [NUM_PADS-1:0]              evt_clr_i,
    output logic [NUM_PADS*IOCELL_CFG_W-1:0] cell_cfg_o,
    output logic [NUM_PADS-1:0]              cell_from_core_o,
    input  logic [NUM_PADS-1:0]              cell_to_core_i
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GUARD  = 2'b01,
        ST_COMMIT = 2'b10
    } state_e;

    state_e                                   state_q, state_d;
    logic [GW-1:0]                            gcnt_q, gcnt_d;
    logic                                     busy_q, busy_d;
    logic                                     ready_q, ready_d;
    logic [NUM_PADS-1:0][1:0]                 sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [NUM_PADS-1:0][IOCELL_CFG_W-1:0]    sh_cfg_q, sh_cfg_d, act_cfg_q, act_cfg_d;
    logic [NUM_PADS-1:0]                      sync1_q, sync2_q;
    logic [NUM_PADS-1:0]                      filt_q, filt_d;
    logic [NUM_PADS-1:0][FW-1:0]              fcnt_q, fcnt_d;
    logic [NUM_PADS-1:0]                      evt_q, evt_d;
    logic [NUM_PADS-1:0][IOCELL_CFG_W-1:0]    cell_cfg_q, cell_cfg_d;
    logic [NUM_PADS-1:0]                      from_core_q, from_core_d;

    logic                                     wr_s;
    logic                                     start_s;
    logic                                     commit_s;
    logic [NUM_PADS-1:0]                      changed_s;
    logic [NUM_PADS-1:0]                      guard_s;

    assign wr_s     = cfg_valid_i & ready_q;
    assign start_s  = cfg_apply_i & ready_q;
    assign commit_s = (state_q == ST_COMMIT);

    // Pads whose shadow differs from active; only those are forced safe while busy.
    always_comb begin
        changed_s = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            changed_s[i] = (sh_mode_q[i] != act_mode_q[i]) || (sh_cfg_q[i] != act_cfg_q[i]);
        end
        if (state_q != ST_IDLE) begin
            guard_s = changed_s;
        end else begin
            guard_s = '0;
        end
    end

    // Apply sequencer next-state; busy also covers the cycle the outputs pick up the new config.
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_GUARD;
                    gcnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (gcnt_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d = ST_COMMIT;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d  = gcnt_q + GW'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gcnt_d  = '0;
            end
        endcase
        busy_d  = (state_d != ST_IDLE) || (state_q != ST_IDLE);
        ready_d = !busy_d;
    end

    // Shadow writes (out-of-range addresses match no pad) and the active commit.
    always_comb begin
        sh_mode_d = sh_mode_q;
        sh_cfg_d  = sh_cfg_q;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (wr_s && (cfg_addr_i == AW'(i))) begin
                sh_mode_d[i] = cfg_wdata_i[WW-1:IOCELL_CFG_W];
                sh_cfg_d[i]  = cfg_wdata_i[IOCELL_CFG_W-1:0];
            end else begin
                sh_mode_d[i] = sh_mode_q[i];
                sh_cfg_d[i]  = sh_cfg_q[i];
            end
        end
        if (commit_s) begin
            act_mode_d = sh_mode_q;
            act_cfg_d  = sh_cfg_q;
        end else begin
            act_mode_d = act_mode_q;
            act_cfg_d  = act_cfg_q;
        end
    end

    // Input conditioning, event flags and next values of the registered pad outputs.
    always_comb begin
        filt_d      = '0;
        fcnt_d      = '0;
        evt_d       = '0;
        cell_cfg_d  = '0;
        from_core_d = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            case (act_mode_q[i])
                2'b10: begin
                    filt_d[i] = sync2_q[i];
                    fcnt_d[i] = '0;
                end
                2'b11: begin
                    if (sync2_q[i] != filt_q[i]) begin
                        if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                            filt_d[i] = sync2_q[i];
                            fcnt_d[i] = '0;
                        end else begin
                            filt_d[i] = filt_q[i];
                            fcnt_d[i] = fcnt_q[i] + FW'(1);
                        end
                    end else begin
                        filt_d[i] = filt_q[i];
                        fcnt_d[i] = '0;
                    end
                end
                default: begin
                    filt_d[i] = 1'b0;
                    fcnt_d[i] = '0;
                end
            endcase
            evt_d[i] = (filt_d[i] & ~filt_q[i] & act_mode_q[i][1]) | (evt_q[i] & ~evt_clr_i[i]);
            if (commit_s && changed_s[i]) begin
                filt_d[i] = 1'b0;
                fcnt_d[i] = '0;
                evt_d[i]  = 1'b0;
            end else begin
                evt_d[i]  = evt_d[i];
            end
            if (guard_s[i]) begin
                cell_cfg_d[i]  = '0;
                from_core_d[i] = 1'b0;
            end else begin
                cell_cfg_d[i]  = act_cfg_q[i];
                from_core_d[i] = (act_mode_q[i] == 2'b01) ? core_out_i[i] : 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gcnt_q      <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            sh_mode_q   <= '0;
            sh_cfg_q    <= '0;
            act_mode_q  <= '0;
            act_cfg_q   <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            fcnt_q      <= '0;
            evt_q       <= '0;
            cell_cfg_q  <= '0;
            from_core_q <= '0;
        end else begin
            state_q     <= state_d;
            gcnt_q      <= gcnt_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            sh_mode_q   <= sh_mode_d;
            sh_cfg_q    <= sh_cfg_d;
            act_mode_q  <= act_mode_d;
            act_cfg_q   <= act_cfg_d;
            sync1_q     <= cell_to_core_i;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            evt_q       <= evt_d;
            cell_cfg_q  <= cell_cfg_d;
            from_core_q <= from_core_d;
        end
    end

    assign cfg_ready_o      = ready_q;
    assign cfg_busy_o       = busy_q;
    assign core_in_o        = filt_q;
    assign evt_rise_o       = evt_q;
    assign cell_cfg_o       = cell_cfg_q;
    assign cell_from_core_o = from_core_q;

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Directed bench for io_bank_ctrl: 8-pad instance for the main flows, 6-pad
// instance for out-of-range addressing.
module tb_io_bank_ctrl;

    typedef struct {
        logic in2;
        logic in4;
        logic clr2;
        logic core2;
        logic core4;
        logic evt2;
        logic evt4;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready, cfg_apply, cfg_busy;
    logic [2:0]  cfg_addr;
    logic [4:0]  cfg_wdata;
    logic [7:0]  core_out, core_in, evt_rise, evt_clr, cell_from_core, cell_to_core;
    logic [23:0] cell_cfg;

    logic        cfg_valid2, cfg_ready2, cfg_apply2, cfg_busy2;
    logic [2:0]  cfg_addr2;
    logic [4:0]  cfg_wdata2;
    logic [5:0]  core_out2, core_in2, evt_rise2, evt_clr2, cell_from_core2, cell_to_core2;
    logic [17:0] cell_cfg2;

    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl[13];

    always #5 clk = ~clk;

    io_bank_ctrl #(.NUM_PADS(8), .IOCELL_CFG_W(3), .GUARD_CYCLES(2), .FILTER_LEN(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_apply_i(cfg_apply), .cfg_busy_o(cfg_busy),
        .core_out_i(core_out), .core_in_o(core_in), .evt_rise_o(evt_rise),
        .evt_clr_i(evt_clr), .cell_cfg_o(cell_cfg), .cell_from_core_o(cell_from_core),
        .cell_to_core_i(cell_to_core)
    );

    io_bank_ctrl #(.NUM_PADS(6), .IOCELL_CFG_W(3), .GUARD_CYCLES(2), .FILTER_LEN(4)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid2), .cfg_ready_o(cfg_ready2), .cfg_addr_i(cfg_addr2),
        .cfg_wdata_i(cfg_wdata2), .cfg_apply_i(cfg_apply2), .cfg_busy_o(cfg_busy2),
        .core_out_i(core_out2), .core_in_o(core_in2), .evt_rise_o(evt_rise2),
        .evt_clr_i(evt_clr2), .cell_cfg_o(cell_cfg2), .cell_from_core_o(cell_from_core2),
        .cell_to_core_i(cell_to_core2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] sl(input int p);
        return cell_cfg[p*3 +: 3];
    endfunction

    task automatic wr(input logic [2:0] a, input logic [1:0] m, input logic [2:0] c);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = {m, c};
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [1:0] m, input logic [2:0] c);
        cfg_valid2 = 1'b1;
        cfg_addr2  = a;
        cfg_wdata2 = {m, c};
        step(1);
        cfg_valid2 = 1'b0;
        chk("oor_ready", 32'(cfg_ready2), 32'd1);
    endtask

    task automatic apply_full();
        cfg_apply = 1'b1;
        step(1);
        cfg_apply = 1'b0;
        step(4);
    endtask

    initial begin
        //           in2   in4   clr2  core2 core4 evt2  evt4
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_apply = 1'b0; cfg_addr = 3'd0; cfg_wdata = 5'd0;
        core_out = 8'h00; evt_clr = 8'h00; cell_to_core = 8'h00;
        cfg_valid2 = 1'b0; cfg_apply2 = 1'b0; cfg_addr2 = 3'd0; cfg_wdata2 = 5'd0;
        core_out2 = 6'h00; evt_clr2 = 6'h00; cell_to_core2 = 6'h00;
        step(3);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_core_in", 32'(core_in), 32'd0);
        chk("rst_evt", 32'(evt_rise), 32'd0);
        chk("rst_cell_cfg", 32'(cell_cfg), 32'd0);
        chk("rst_from_core", 32'(cell_from_core), 32'd0);
        rst_n = 1'b1;
        step(1);

        // 6-pad bank: last valid pad accepted, addresses 6 and 7 dropped
        core_out2 = 6'h3F;
        wr2(3'd5, 2'b01, 3'b100);
        wr2(3'd6, 2'b01, 3'b111);
        wr2(3'd7, 2'b01, 3'b011);
        cfg_apply2 = 1'b1;
        step(1);
        cfg_apply2 = 1'b0;
        step(4);
        chk("oor_cell_cfg", 32'(cell_cfg2), 32'h20000);
        chk("oor_from_core", 32'(cell_from_core2), 32'h20);

        // pad 3 output commit and its timing
        core_out = 8'hFF;
        wr(3'd3, 2'b01, 3'b101);
        cfg_apply = 1'b1;
        step(1);
        cfg_apply = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("a_busy", 32'(cfg_busy), 32'd1);
            chk("a_ready", 32'(cfg_ready), 32'd0);
            chk("a_cfg3_guard", 32'(sl(3)), 32'd0);
            chk("a_fc3_guard", 32'(cell_from_core[3]), 32'd0);
            step(1);
        end
        chk("a_busy_done", 32'(cfg_busy), 32'd0);
        chk("a_ready_done", 32'(cfg_ready), 32'd1);
        chk("a_cfg3", 32'(sl(3)), 32'h5);
        chk("a_fc3", 32'(cell_from_core[3]), 32'd1);
        core_out[3] = 1'b0;
        step(1);
        chk("a_fc3_low", 32'(cell_from_core[3]), 32'd0);
        core_out[3] = 1'b1;
        step(1);
        chk("a_fc3_high", 32'(cell_from_core[3]), 32'd1);

        // unchanged pad 0 undisturbed while pads 1 and 3 are reconfigured
        wr(3'd0, 2'b01, 3'b011);
        apply_full();
        chk("b_cfg0", 32'(sl(0)), 32'h3);
        wr(3'd1, 2'b01, 3'b110);
        wr(3'd3, 2'b01, 3'b010);
        cfg_apply = 1'b1;
        step(1);
        cfg_apply = 1'b0;
        chk("b_cfg3_old", 32'(sl(3)), 32'h5);
        for (int k = 1; k < 4; k++) begin
            step(1);
            chk("b_cfg0_hold", 32'(sl(0)), 32'h3);
            chk("b_fc0_hold", 32'(cell_from_core[0]), 32'd1);
            chk("b_cfg3_guard", 32'(sl(3)), 32'd0);
            chk("b_fc3_guard", 32'(cell_from_core[3]), 32'd0);
        end
        step(1);
        chk("b_cfg3_new", 32'(sl(3)), 32'h2);
        chk("b_cfg1_new", 32'(sl(1)), 32'h6);
        chk("b_fc1", 32'(cell_from_core[1]), 32'd1);
        chk("b_cfg0_end", 32'(sl(0)), 32'h3);

        // apply with nothing changed: full sequence, outputs steady
        cfg_apply = 1'b1;
        step(1);
        cfg_apply = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("n_busy", 32'(cfg_busy), (k < 4) ? 32'd1 : 32'd0);
            chk("n_cfg_steady", 32'(cell_cfg), 32'h433);
            chk("n_fc_steady", 32'(cell_from_core), 32'h0B);
            if (k < 4) step(1);
        end

        // write and apply together; apply held while busy is ignored
        cfg_valid = 1'b1;
        cfg_addr  = 3'd2;
        cfg_wdata = {2'b10, 3'b001};
        cfg_apply = 1'b1;
        step(1);
        cfg_valid = 1'b0;
        step(4);
        cfg_apply = 1'b0;
        chk("c_busy_done", 32'(cfg_busy), 32'd0);
        chk("c_cfg2", 32'(sl(2)), 32'h1);
        chk("c_fc2", 32'(cell_from_core[2]), 32'd0);
        step(1);
        chk("c_single_seq", 32'(cfg_busy), 32'd0);
        wr(3'd4, 2'b11, 3'b000);
        apply_full();

        // input path: pad 2 direct (mode 10), pad 4 filtered (mode 11)
        for (int k = 0; k < 13; k++) begin
            cell_to_core[2] = tbl[k].in2;
            cell_to_core[4] = tbl[k].in4;
            evt_clr[2]      = tbl[k].clr2;
            step(1);
            chk("t_core2", 32'(core_in[2]), 32'(tbl[k].core2));
            chk("t_core4", 32'(core_in[4]), 32'(tbl[k].core4));
            chk("t_evt2", 32'(evt_rise[2]), 32'(tbl[k].evt2));
            chk("t_evt4", 32'(evt_rise[4]), 32'(tbl[k].evt4));
        end
        evt_clr = 8'h00;

        // reset in the middle of GUARD
        wr(3'd5, 2'b01, 3'b111);
        cfg_apply = 1'b1;
        step(1);
        cfg_apply = 1'b0;
        step(1);
        chk("d_busy_pre", 32'(cfg_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("d_ready", 32'(cfg_ready), 32'd1);
        chk("d_busy", 32'(cfg_busy), 32'd0);
        chk("d_cell_cfg", 32'(cell_cfg), 32'd0);
        chk("d_from_core", 32'(cell_from_core), 32'd0);
        chk("d_core_in", 32'(core_in), 32'd0);
        chk("d_evt", 32'(evt_rise), 32'd0);
        cell_to_core = 8'h00;
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("d_busy_after", 32'(cfg_busy), 32'd0);
        chk("d_ready_after", 32'(cfg_ready), 32'd1);
        chk("d_cfg_after", 32'(cell_cfg), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
